// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and access-legality helper for the LSU alignment unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ISSUE,
    S_RD_DATA,
    S_WR_ISSUE,
    S_RESP
  } lsu_state_t;

  // True when the access is misaligned for its size or uses an unsupported funct3.
  function automatic logic access_illegal(input logic write, input logic [2:0] f3,
                                          input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    if (write) begin
      case (f3)
        F3_B:    bad = 1'b0;
        F3_H:    bad = off[0];
        F3_W:    bad = |off;
        default: bad = 1'b1;
      endcase
    end else begin
      case (f3)
        F3_B, F3_BU: bad = 1'b0;
        F3_H, F3_HU: bad = off[0];
        F3_W:        bad = |off;
        default:     bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte/halfword lane logic: load extraction with extension, and store merge into an old word.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Pick the addressed byte and halfword out of the memory word.
  always_comb begin
    sel_byte = '0;
    case (offset)
      2'd0: sel_byte = old_word[7:0];
      2'd1: sel_byte = old_word[15:8];
      2'd2: sel_byte = old_word[23:16];
      2'd3: sel_byte = old_word[31:24];
      default: sel_byte = '0;
    endcase
    sel_half = offset[1] ? old_word[31:16] : old_word[15:0];
  end

  // Extend the selected lane according to the load type.
  always_comb begin
    load_data = '0;
    case (funct3)
      F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
      F3_BU:   load_data = {24'd0, sel_byte};
      F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
      F3_HU:   load_data = {16'd0, sel_half};
      F3_W:    load_data = old_word;
      default: load_data = '0;
    endcase
  end

  // Merge the new byte/half into the old word; full words pass straight through.
  always_comb begin
    store_word = old_word;
    case (funct3)
      F3_B: begin
        case (offset)
          2'd0: store_word[7:0]   = new_data[7:0];
          2'd1: store_word[15:8]  = new_data[7:0];
          2'd2: store_word[23:16] = new_data[7:0];
          2'd3: store_word[31:24] = new_data[7:0];
          default: store_word = old_word;
        endcase
      end
      F3_H: begin
        if (offset[1]) store_word[31:16] = new_data[15:0];
        else           store_word[15:0]  = new_data[15:0];
      end
      default: store_word = new_data;
    endcase
  end

endmodule

// File: rtl/lsu_align.sv
// Load/store alignment unit in front of a word-only memory; SB/SH done as read-modify-write.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_misaligned,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  lsu_state_t  state, state_nxt;
  logic        write_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        mis_q;
  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] store_word;

  assign req_err = access_illegal(req_write, req_funct3, req_addr[1:0]);

  lsu_lane u_lane (
    .old_word   (mem_rdata),
    .new_data   (wdata_q),
    .funct3     (f3_q),
    .offset     (addr_q[1:0]),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // State register plus request capture and response data registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      write_q <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            write_q <= req_write;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            if (req_err) begin
              rdata_q <= '0;
              mis_q   <= 1'b1;
            end
          end
        end
        S_RD_DATA: begin
          // Stores keep the merged word for WR_ISSUE; loads publish their result now.
          if (write_q) begin
            wdata_q <= store_word;
          end else begin
            rdata_q <= load_data;
            mis_q   <= 1'b0;
          end
        end
        S_WR_ISSUE: begin
          rdata_q <= '0;
          mis_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Next-state sequencing and memory/handshake outputs.
  always_comb begin
    state_nxt   = state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    mem_write   = 1'b0;
    mem_address = {addr_q[31:2], 2'b00};
    mem_wdata   = '0;
    case (state)
      S_IDLE: begin
        req_ready   = 1'b1;
        mem_address = '0;
        if (req_valid) begin
          if (req_err)                        state_nxt = S_RESP;
          else if (req_write && req_funct3 == F3_W) state_nxt = S_WR_ISSUE;
          else                                state_nxt = S_RD_ISSUE;
        end
      end
      S_RD_ISSUE: state_nxt = S_RD_DATA;
      S_RD_DATA:  state_nxt = write_q ? S_WR_ISSUE : S_RESP;
      S_WR_ISSUE: begin
        // Gated by reset so an aborted access never reaches memory.
        mem_write = ~reset;
        mem_wdata = wdata_q;
        state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid = ~reset;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign rsp_rdata      = rdata_q;
  assign rsp_misaligned = mis_q;

endmodule

// File: tb/tb_lsu_align.sv
// Directed self-checking bench for lsu_align with a registered word-memory model.
module tb_lsu_align;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_misaligned;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;

  int total = 0;
  int bad = 0;
  int wr_count = 0;
  int rsp_count = 0;
  int addr_bad = 0;

  logic [31:0] mem [0:63];

  lsu_align dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_write      (req_write),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_ready      (req_ready),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_misaligned (rsp_misaligned),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata)
  );

  always #5 clk = ~clk;

  // Word memory: registered read, returns 0 the cycle after a write.
  always @(posedge clk) begin
    if (mem_address[31:8] != 24'd0 || mem_address[1:0] != 2'd0) addr_bad <= addr_bad + 1;
    if (mem_write) begin
      mem[mem_address[7:2]] <= mem_wdata;
      mem_rdata <= 32'd0;
    end else begin
      mem_rdata <= mem[mem_address[7:2]];
    end
  end

  always @(posedge clk) begin
    if (mem_write) wr_count <= wr_count + 1;
    if (rsp_valid) rsp_count <= rsp_count + 1;
  end

  // Issue one request and follow it to its response (bounded).
  task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output logic mis,
                        output int lat, output int nwr, output logic [31:0] wd,
                        output int rdy_hi);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1; nwr = 0; wd = 32'd0; rdy_hi = 0;
    while (!rsp_valid && lat < 20) begin
      if (mem_write) begin nwr++; wd = mem_wdata; end
      if (req_ready) rdy_hi++;
      @(posedge clk); #1; lat++;
    end
    if (mem_write) begin nwr++; wd = mem_wdata; end
    if (req_ready) rdy_hi++;
    rd = rsp_rdata; mis = rsp_misaligned;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    total++; if ({rsp_valid, rsp_misaligned, mem_write} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {rsp_valid, rsp_misaligned, mem_write}); end
    total++; if (rsp_rdata !== 32'd0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rsp_rdata); end
    total++; if (mem_address !== 32'd0 || mem_wdata !== 32'd0) begin bad++; $display("FAIL reset_mem got=%h/%h exp=0/0", mem_address, mem_wdata); end
  endtask

  task automatic test_loads;
    logic [31:0] rd, wd; logic mis; int lat, nwr, rh;
    do_req(1'b1, 3'b010, 32'h10, 32'h8000_00F0, rd, mis, lat, nwr, wd, rh);
    total++; if (lat !== 2 || nwr !== 1 || wd !== 32'h8000_00F0) begin bad++; $display("FAIL sw_preload got lat=%0d nwr=%0d wd=%h exp 2/1/800000f0", lat, nwr, wd); end
    do_req(1'b0, 3'b000, 32'h10, 32'h0, rd, mis, lat, nwr, wd, rh);
    total++; if (rd !== 32'hFFFF_FFF0 || mis !== 1'b0) begin bad++; $display("FAIL lb got=%h mis=%b exp=fffffff0", rd, mis); end
    total++; if (lat !== 3 || nwr !== 0 || rh !== 0) begin bad++; $display("FAIL lb_timing got lat=%0d nwr=%0d rdy=%0d exp 3/0/0", lat, nwr, rh); end
    do_req(1'b0, 3'b100, 32'h10, 32'h0, rd, mis, lat, nwr, wd, rh);
    total++; if (rd !== 32'h0000_00F0) begin bad++; $display("FAIL lbu got=%h exp=000000f0", rd); end
    do_req(1'b0, 3'b101, 32'h12, 32'h0, rd, mis, lat, nwr, wd, rh);
    total++; if (rd !== 32'h0000_8000) begin bad++; $display("FAIL lhu got=%h exp=00008000", rd); end
    do_req(1'b0, 3'b001, 32'h12, 32'h0, rd, mis, lat, nwr, wd, rh);
    total++; if (rd !== 32'hFFFF_8000) begin bad++; $display("FAIL lh got=%h exp=ffff8000", rd); end
    do_req(1'b0, 3'b000, 32'h13, 32'h0, rd, mis, lat, nwr, wd, rh);
    total++; if (rd !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_top got=%h exp=ffffff80", rd); end
    do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, mis, lat, nwr, wd, rh);
    total++; if (rd !== 32'h8000_00F0 || lat !== 3) begin bad++; $display("FAIL lw got=%h lat=%0d exp=800000f0/3", rd, lat); end
  endtask

  task automatic test_stores;
    logic [31:0] rd, wd; logic mis; int lat, nwr, rh;
    do_req(1'b1, 3'b010, 32'h20, 32'h1122_3344, rd, mis, lat, nwr, wd, rh);
    do_req(1'b1, 3'b000, 32'h21, 32'h5555_55AB, rd, mis, lat, nwr, wd, rh);
    total++; if (nwr !== 1 || wd !== 32'h1122_AB44) begin bad++; $display("FAIL sb_merge got nwr=%0d wd=%h exp 1/1122ab44", nwr, wd); end
    total++; if (lat !== 4 || rd !== 32'd0 || mis !== 1'b0) begin bad++; $display("FAIL sb_rsp got lat=%0d rd=%h mis=%b exp 4/0/0", lat, rd, mis); end
    do_req(1'b0, 3'b010, 32'h20, 32'h0, rd, mis, lat, nwr, wd, rh);
    total++; if (rd !== 32'h1122_AB44) begin bad++; $display("FAIL sb_readback got=%h exp=1122ab44", rd); end
    do_req(1'b1, 3'b010, 32'h20, 32'h1122_3344, rd, mis, lat, nwr, wd, rh);
    do_req(1'b1, 3'b001, 32'h22, 32'h7777_BEEF, rd, mis, lat, nwr, wd, rh);
    total++; if (nwr !== 1 || wd !== 32'hBEEF_3344 || lat !== 4) begin bad++; $display("FAIL sh_merge got nwr=%0d wd=%h lat=%0d exp 1/beef3344/4", nwr, wd, lat); end
    do_req(1'b1, 3'b001, 32'h20, 32'h0000_CAFE, rd, mis, lat, nwr, wd, rh);
    total++; if (wd !== 32'hBEEF_CAFE) begin bad++; $display("FAIL sh_low got=%h exp=beefcafe", wd); end
    do_req(1'b1, 3'b010, 32'h24, 32'hDEAD_BEEF, rd, mis, lat, nwr, wd, rh);
    total++; if (lat !== 2 || nwr !== 1 || wd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL sw got lat=%0d nwr=%0d wd=%h exp 2/1/deadbeef", lat, nwr, wd); end
    do_req(1'b0, 3'b010, 32'h24, 32'h0, rd, mis, lat, nwr, wd, rh);
    total++; if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL sw_readback got=%h exp=deadbeef", rd); end
  endtask

  task automatic test_misaligned;
    logic [31:0] rd, wd; logic mis; int lat, nwr, rh;
    do_req(1'b1, 3'b010, 32'h20, 32'h1122_3344, rd, mis, lat, nwr, wd, rh);
    do_req(1'b0, 3'b010, 32'h13, 32'h0, rd, mis, lat, nwr, wd, rh);
    total++; if (mis !== 1'b1 || rd !== 32'd0 || lat !== 1 || nwr !== 0) begin bad++; $display("FAIL lw_mis got mis=%b rd=%h lat=%0d nwr=%0d exp 1/0/1/0", mis, rd, lat, nwr); end
    do_req(1'b1, 3'b001, 32'h21, 32'hFFFF_FFFF, rd, mis, lat, nwr, wd, rh);
    total++; if (mis !== 1'b1 || rd !== 32'd0 || lat !== 1 || nwr !== 0) begin bad++; $display("FAIL sh_mis got mis=%b rd=%h lat=%0d nwr=%0d exp 1/0/1/0", mis, rd, lat, nwr); end
    do_req(1'b0, 3'b011, 32'h20, 32'h0, rd, mis, lat, nwr, wd, rh);
    total++; if (mis !== 1'b1 || lat !== 1) begin bad++; $display("FAIL ld_f3_illegal got mis=%b lat=%0d exp 1/1", mis, lat); end
    do_req(1'b1, 3'b100, 32'h20, 32'h0, rd, mis, lat, nwr, wd, rh);
    total++; if (mis !== 1'b1 || nwr !== 0) begin bad++; $display("FAIL st_f3_illegal got mis=%b nwr=%0d exp 1/0", mis, nwr); end
    do_req(1'b0, 3'b010, 32'h20, 32'h0, rd, mis, lat, nwr, wd, rh);
    total++; if (rd !== 32'h1122_3344 || mis !== 1'b0) begin bad++; $display("FAIL mis_unchanged got=%h mis=%b exp=11223344/0", rd, mis); end
  endtask

  task automatic test_reset_abort;
    logic [31:0] rd, wd; logic mis; int lat, nwr, rh, w0, r0;
    w0 = wr_count; r0 = rsp_count;
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000; req_addr = 32'h21; req_wdata = 32'hAB;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b exp=1", req_ready); end
    repeat (5) @(posedge clk);
    #1;
    total++; if (wr_count !== w0 || rsp_count !== r0) begin bad++; $display("FAIL abort_quiet got wr=%0d rsp=%0d exp %0d/%0d", wr_count, rsp_count, w0, r0); end
    do_req(1'b0, 3'b010, 32'h20, 32'h0, rd, mis, lat, nwr, wd, rh);
    total++; if (rd !== 32'h1122_3344) begin bad++; $display("FAIL abort_mem got=%h exp=11223344", rd); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] vals [0:2];
    logic [31:0] resp [0:7];
    int ni, nr, cyc, r0;
    logic was_rdy;
    vals[0] = 32'hA5A5_0001; vals[1] = 32'h5A5A_0002; vals[2] = 32'h0F0F_0003;
    r0 = rsp_count;
    ni = 0; nr = 0; cyc = 0;
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h30; req_wdata = vals[0];
    was_rdy = req_ready;
    while (nr < 6 && cyc < 200) begin
      @(posedge clk); #1; cyc++;
      if (was_rdy && req_valid) begin
        ni++;
        if (ni < 6) begin
          req_write = (ni % 2 == 0);
          req_addr  = 32'h30 + 32'(4 * (ni / 2));
          req_wdata = (ni % 2 == 0) ? vals[ni / 2] : 32'h0;
        end else begin
          req_valid = 1'b0;
        end
      end
      if (rsp_valid) begin resp[nr] = rsp_rdata; nr++; end
      was_rdy = req_ready;
    end
    req_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    total++; if (ni !== 6 || nr !== 6) begin bad++; $display("FAIL b2b_counts got acc=%0d rsp=%0d exp 6/6", ni, nr); end
    total++; if (rsp_count - r0 !== 6) begin bad++; $display("FAIL b2b_pulses got=%0d exp=6", rsp_count - r0); end
    for (int k = 0; k < 3; k++) begin
      total++; if (resp[2*k+1] !== vals[k]) begin bad++; $display("FAIL b2b_lw%0d got=%h exp=%h", k, resp[2*k+1], vals[k]); end
    end
    total++; if (addr_bad !== 0) begin bad++; $display("FAIL mem_addr_align got=%0d exp=0", addr_bad); end
  endtask

  initial begin
    test_reset;
    test_loads;
    test_stores;
    test_misaligned;
    test_reset_abort;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
